// File: rtl/arb_req_agent.sv
// Requester agent: buffers source words and presents req; on gnt pops one word onto the bus.
// Latency: one cycle from gnt to bus word. Backpressure: in_ready drops when the FIFO holds DEPTH words.

module arb_req_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_dat,
    output logic [DATA_W-1:0]        rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module arb_req_agent #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              starve,
    output logic              proto_err,
    output logic [CNT_W-1:0]  grant_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] MAX_C   = WW'(MAX_WAIT);

    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head_dat;
    logic              push;
    logic              pop;
    logic              empty;
    logic [WW-1:0]     wait_cnt;
    logic [WW-1:0]     wait_nxt;

    assign empty    = (count == '0);
    assign in_ready = (count < DEPTH_C);
    assign push     = in_valid & in_ready;
    assign pop      = gnt & ~empty;

    // The arbiter answers req one cycle late, so drop req while the last word is being granted.
    assign req = (count >= CW'(2)) | ((count == CW'(1)) & ~gnt);

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_dat (in_data),
        .rd_dat (head_dat),
        .count  (count)
    );

    always_comb begin
        wait_nxt = wait_cnt;
        if (gnt || !req) begin
            wait_nxt = '0;
        end else if (wait_cnt != MAX_C) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
            starve    <= 1'b0;
            proto_err <= 1'b0;
            grant_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            bus_valid <= pop;
            if (pop) begin
                bus_data  <= head_dat;
                grant_cnt <= grant_cnt + 1'b1;
            end
            if (gnt && empty) begin
                proto_err <= 1'b1;
            end
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt == MAX_C);
        end
    end
endmodule
